// File: rtl/psum_pkg.sv
// Shared types and lane arithmetic for the partial-sum accumulator.
// Lane helpers work on a fixed 32-bit signed container; callers sign-extend in and truncate out.
package psum_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int LANE_MAX_W = 32;
   localparam int LANE_SUM_W = LANE_MAX_W + 1;

   // Signed add saturated to the range of a w-bit lane (w <= LANE_MAX_W).
   function automatic logic signed [LANE_MAX_W-1:0] lane_sat_add(
      input logic signed [LANE_MAX_W-1:0] a,
      input logic signed [LANE_MAX_W-1:0] b,
      input int                           w
   );
      logic signed [LANE_SUM_W-1:0] sum;
      logic signed [LANE_SUM_W-1:0] hi;
      logic signed [LANE_SUM_W-1:0] lo;
      sum = {a[LANE_MAX_W-1], a} + {b[LANE_MAX_W-1], b};
      hi  = (LANE_SUM_W'(1) <<< (w - 1)) - LANE_SUM_W'(1);
      lo  = -hi - LANE_SUM_W'(1);
      if (sum > hi) begin
         return hi[LANE_MAX_W-1:0];
      end else if (sum < lo) begin
         return lo[LANE_MAX_W-1:0];
      end
      return sum[LANE_MAX_W-1:0];
   endfunction

   function automatic logic signed [LANE_MAX_W-1:0] lane_relu(
      input logic signed [LANE_MAX_W-1:0] v,
      input logic                         en
   );
      return (en && (v < 0)) ? '0 : v;
   endfunction

endpackage

// File: rtl/psum_buf.sv
// Accumulation buffer: depth words, one combinational read port, one synchronous write port.
// No reset: every entry is written on pass 0 before it is ever read.
module psum_buf #(
   parameter int depth = 16,
   parameter int width = 128,
   parameter int AW    = $clog2(depth)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [width-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [width-1:0] rd_data
);

   logic [width-1:0] mem_q [depth];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/psum_accum.sv
// Multi-pass partial-sum accumulator: sums passes of psum words into a buffer,
// then drains the buffer (optionally ReLU'd) through a valid/ready port.
module psum_accum
   import psum_pkg::*;
#(
   parameter  int col     = 8,
   parameter  int psum_bw = 16,
   parameter  int depth   = 16,
   localparam int AW      = $clog2(depth),
   localparam int W       = psum_bw * col
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW:0]   cfg_rows,
   input  logic [7:0]    cfg_passes,
   input  logic          cfg_relu,
   input  logic          in_valid,
   input  logic [W-1:0]  in_data,
   output logic          in_ready,
   output logic          out_valid,
   output logic [W-1:0]  out_data,
   input  logic          out_ready,
   output logic          busy,
   output logic          done
);

   localparam logic [AW:0] DEPTH_C = (AW + 1)'(depth);

   state_t        state_q, state_d;
   logic [AW-1:0] row_q, row_d;
   logic [7:0]    pass_q, pass_d;
   logic [AW:0]   rows_q, rows_d;
   logic [7:0]    passes_q, passes_d;
   logic          relu_q, relu_d;

   logic [W-1:0]  rd_word;
   logic [W-1:0]  wr_word;
   logic [W-1:0]  drain_word;
   logic          xfer;
   logic          last_row;
   logic          last_pass;

   assign xfer      = (state_q == ACCUM) && in_valid;
   assign last_row  = ({1'b0, row_q} == (rows_q - 1'b1));
   assign last_pass = (pass_q == (passes_q - 8'd1));

   psum_buf #(
      .depth (depth),
      .width (W),
      .AW    (AW)
   ) u_buf (
      .clk     (clk),
      .wr_en   (xfer),
      .wr_addr (row_q),
      .wr_data (wr_word),
      .rd_addr (row_q),
      .rd_data (rd_word)
   );

   // Pass 0 overwrites stale buffer contents; later passes saturate-add per lane.
   for (genvar i = 0; i < col; i++) begin : g_lane
      logic [psum_bw-1:0] sum_lane;
      assign sum_lane = psum_bw'(lane_sat_add(
                           LANE_MAX_W'($signed(rd_word[psum_bw*i +: psum_bw])),
                           LANE_MAX_W'($signed(in_data[psum_bw*i +: psum_bw])),
                           psum_bw));
      assign wr_word[psum_bw*i +: psum_bw] =
         (pass_q == 8'd0) ? in_data[psum_bw*i +: psum_bw] : sum_lane;
      assign drain_word[psum_bw*i +: psum_bw] = psum_bw'(lane_relu(
         LANE_MAX_W'($signed(rd_word[psum_bw*i +: psum_bw])), relu_q));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         row_q    <= '0;
         pass_q   <= '0;
         rows_q   <= '0;
         passes_q <= '0;
         relu_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         pass_q   <= pass_d;
         rows_q   <= rows_d;
         passes_q <= passes_d;
         relu_q   <= relu_d;
      end
   end

   // A zero-length job skips straight to DONE so the caller still sees a done pulse.
   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      pass_d   = pass_q;
      rows_d   = rows_q;
      passes_d = passes_q;
      relu_d   = relu_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               rows_d   = (cfg_rows > DEPTH_C) ? DEPTH_C : cfg_rows;
               passes_d = cfg_passes;
               relu_d   = cfg_relu;
               row_d    = '0;
               pass_d   = '0;
               state_d  = ((cfg_rows == '0) || (cfg_passes == 8'd0)) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (xfer) begin
               if (last_row) begin
                  row_d  = '0;
                  pass_d = pass_q + 8'd1;
                  if (last_pass) begin
                     state_d = DRAIN;
                  end
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (out_ready) begin
               if (last_row) begin
                  state_d = DONE;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == DRAIN);
   assign out_data  = (state_q == DRAIN) ? drain_word : '0;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);

endmodule

// File: doc/psum_accum.md
PSUM_ACCUM -- requirements
Module: psum_accum

Interface
REQ-001 Parameter col, default 8: lanes per word, matching the MAC array column count.
REQ-002 Parameter psum_bw, default 16: signed partial-sum width per lane.
REQ-003 Parameter depth, default 16: accumulation-buffer entries; AW = $clog2(depth).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state.
REQ-006 start  input  1  one-cycle pulse that launches a job; honoured in IDLE only.
REQ-007 cfg_rows  input  AW+1  words per pass; legal range 1..depth.
REQ-008 cfg_passes  input  8  number of accumulation passes.
REQ-009 cfg_relu  input  1  apply ReLU during drain.
REQ-010 in_valid  input  1  upstream psum word available (output-FIFO valid).
REQ-011 in_data  input  psum_bw*col  psum word; lane i occupies bits [psum_bw*(i+1)-1 : psum_bw*i].
REQ-012 in_ready  output  1  word accepted this cycle; drives output-FIFO rd.
REQ-013 out_valid  output  1  drained word available.
REQ-014 out_data  output  psum_bw*col  drained word.
REQ-015 out_ready  input  1  downstream accepts out_data.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse at job end.

Function
REQ-018 FSM states: IDLE, ACCUM, DRAIN, DONE.
REQ-019 IDLE + start: latch cfg_* into internal registers; clear row and pass counters; go to ACCUM.
REQ-020 cfg_rows or cfg_passes equal to 0 at start: go directly to DONE; buffer unchanged.
REQ-021 cfg_rows > depth: clamp to depth.
REQ-022 in_ready = (state == ACCUM); a transfer occurs only when in_valid and in_ready are both high.
REQ-023 Transfer on pass 0: buf[row] <= in_data, ignoring prior buffer contents.
REQ-024 Transfer on pass > 0: buf[row] <= buf[row] + in_data, per lane, signed, saturating to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
REQ-025 After each transfer, row increments; at row == rows-1 it wraps to 0 and pass increments.
REQ-026 Transfer at row == rows-1 and pass == passes-1: go to DRAIN with row = 0 on the next cycle.
REQ-027 DRAIN: out_valid = 1; out_data = buf[row], with each negative lane forced to 0 when relu is latched.
REQ-028 DRAIN: out_data holds stable while out_valid && !out_ready.
REQ-029 DRAIN: on out_valid && out_ready, row increments; the handshake at row == rows-1 goes to DONE.
REQ-030 DONE: done = 1 for exactly one cycle, then return to IDLE.
REQ-031 start outside IDLE: ignored; latched cfg unaffected.
REQ-032 Throughput: one transfer per cycle in ACCUM; one word per cycle in DRAIN.
REQ-033 Latency: final accepted input to first out_valid is exactly 1 cycle.

Reset
REQ-034 Reset (asynchronous, including mid-operation): state = IDLE; row, pass and cfg registers = 0.
REQ-035 Reset values of outputs: in_ready, out_valid, busy and done = 0; out_data = 0.
REQ-036 Reset need not clear buffer contents; they are fully overwritten on pass 0 before any read.

Structure
REQ-037 Shared package psum_pkg holds the FSM state enumeration and the lane saturating-add/ReLU function.
REQ-038 Sub-module psum_buf: depth x (psum_bw*col) register file with one combinational read port and one synchronous write port.
REQ-039 Lane arithmetic is a generate loop over col.

Verification
REQ-040 rows=4, passes=3, every lane of input k = k+1, in_valid always high: drained lanes = 3, 6, 9, 12; done pulses once.
REQ-041 rows=1, passes=2, lane0 = 0x7000 on both passes: drained lane0 = 0x7FFF (positive saturation); a matching negative case drains 0x8000.
REQ-042 relu=1, lane values {-5, 7, 0, -1, ...}: drained {0, 7, 0, 0, ...}; relu=0 passes values unchanged.
REQ-043 Random in_valid gaps and out_ready stalls: results identical to the gap-free run; out_data stable during stalls.
REQ-044 Reset asserted mid-ACCUM (pass 1, row 2): next cycle state IDLE, in_ready = 0; a new job gives correct sums.
REQ-045 start with cfg_rows=0: done one cycle after start, in_ready never asserted; start pulsed while busy is ignored.
